// File: rtl/handshake_port.sv
// handshake_port: one endpoint of a token-ring clock-domain crossing carrying WIDTH-bit words.
// Optional even parity on the bus word is enabled by defining HANDSHAKE_PORT_PARITY_EN.
module handshake_port #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int OWNER       = 0,
`ifdef HANDSHAKE_PORT_PARITY_EN
  localparam int BW = WIDTH + 2
`else
  localparam int BW = WIDTH + 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_in,
  output logic             tok_out,
  input  logic [BW-1:0]    bus_in,
  output logic [BW-1:0]    bus_out,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             parity_err
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tok_q, tok_d;
  logic [BW-1:0]          bus_q, bus_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tok_s, held, in_v, pass;

  assign tok_s = sync_q[SYNC_STAGES-1];
  // The owner starts holding the token, so it holds whenever the two token bits agree.
  assign held  = (OWNER != 0) ? (tok_q == tok_s) : (tok_q != tok_s);
  assign in_v  = bus_in[WIDTH];
  assign pass  = held && (!in_v || !rx_valid_q || rx_ready);

  always_comb begin
    tok_d      = tok_q;
    bus_d      = bus_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (pass) begin
      tok_d = ~tok_q;
      if (in_v) begin
        rx_data_d  = bus_in[WIDTH-1:0];
        rx_valid_d = 1'b1;
      end
      if (tx_valid) begin
        bus_d[WIDTH]     = 1'b1;
        bus_d[WIDTH-1:0] = tx_data;
      end else begin
        bus_d[WIDTH] = 1'b0;
      end
    end
`ifdef HANDSHAKE_PORT_PARITY_EN
    bus_d[WIDTH+1] = ^bus_d[WIDTH:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      tok_q      <= 1'b0;
      bus_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], tok_in};
      tok_q      <= tok_d;
      bus_q      <= bus_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef HANDSHAKE_PORT_PARITY_EN
  logic perr_q, perr_d;

  // A corrupted word is still delivered; the error only flags it alongside rx_valid.
  assign perr_d = pass && in_v && (^bus_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign tok_out  = tok_q;
  assign bus_out  = bus_q;
  assign tx_ready = pass;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/handshake_port.md
# handshake_port

- One endpoint of a parametrised token-ring clock-domain crossing. It runs in a single clock domain.
- Two instances, one per clock domain, are wired back to back: each instance's `tok_out`/`bus_out` drive the other's `tok_in`/`bus_in`.
- The pair forms a full-duplex word link with valid/ready user interfaces on both sides. Holding the token grants the right to sample the peer's bus and to drive our own.
- This block generalises the fixed 1-bit token handshake to WIDTH-bit payloads, configurable synchronizer depth and backpressure.

## Interface
Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `WIDTH`, 16: payload bits per word.
- `SYNC_STAGES`, 2: flops on `tok_in` before use; legal range 2–4.
- `OWNER`, 0: set to 1 on exactly one side of the pair; that side holds the token after reset.

Bus width: BW = WIDTH+1, or WIDTH+2 with `HANDSHAKE_PORT_PARITY_EN`.

Ports:
- `clk` in 1: port clock.
- `rst` in 1: synchronous, active-high reset.
- `tok_in` in 1: peer's `tok_out`, asynchronous.
- `tok_out` out 1: registered token bit to the peer.
- `bus_in` in BW: peer's `bus_out`. It is quasi-static and valid only while we hold the token.
- `bus_out` out BW: registered; bit WIDTH is the valid flag and bits WIDTH-1:0 carry the data.
- `tx_data` in WIDTH: word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: combinational; a word is accepted in a cycle where `tx_valid && tx_ready`.
- `rx_data` out WIDTH: received word, registered.
- `rx_valid` out 1: `rx_data` holds an unconsumed word.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `parity_err` out 1: one-cycle error pulse; tied to 0 without the macro.

## Operation
- Synchronizer: `tok_in` passes through `SYNC_STAGES` flops to produce `tok_s`.
- Token test: `held` = (`tok_out` == `tok_s`) when OWNER=1, else (`tok_out` != `tok_s`).
- Incoming word: `in_v` = `bus_in[WIDTH]`.
- `pass` = `held && (!in_v || !rx_valid || rx_ready)`.
- `tx_ready` = `pass`.
- On a `pass` cycle, at the edge:
  - `tok_out` toggles.
  - If `in_v`: `rx_data <= bus_in[WIDTH-1:0]`, `rx_valid <= 1`.
  - If `tx_valid`: `bus_out <= {1, tx_data}`; otherwise `bus_out[WIDTH] <= 0` and the data bits hold.
- `rx_valid` clears on `rx_valid && rx_ready` unless a new word loads in the same cycle; the load takes priority, giving back-to-back words.
- `held` and not `pass`: the rx buffer is full and not draining. The token stays, `bus_out` and `tok_out` hold, and the peer stalls.
- `bus_out` changes only on the edge where `tok_out` toggles. The peer cannot sample it for at least `SYNC_STAGES` of its own clocks, so `bus_in`→capture is a declared false/multicycle path.
- Empty words: a pass with no `tx_valid` still circulates the token, carrying `valid=0`, so the ring never stops.

## Timing
- Reset values: `tok_out`=0, sync chain=0, `bus_out`=0, `rx_data`=0, `rx_valid`=0, `parity_err`=0.
- After reset, only the OWNER=1 side sees `held`=1, in the first cycle after `rst` deasserts.
- Receive latency: a `tok_in` edge reaches `held` after `SYNC_STAGES` cycles. `tok_out` toggles and `rx_valid` rises on the next edge if `pass`.
- Ring period (no stalls, equal clocks): 2·(SYNC_STAGES+1) cycles, i.e. 6 at defaults; one word per direction per period.
- `tx_ready` is never asserted when `held`=0.
- Reset mid-operation: both ports must be reset within overlapping windows. A single-sided reset is unsupported; the ring state is undefined until both sides are reset.

## Configuration
- `HANDSHAKE_PORT_PARITY_EN` defined:
  - `bus_out[WIDTH+1]` carries even parity over `bus_out[WIDTH:0]`.
  - On a `pass` with `in_v`, a parity mismatch on `bus_in` pulses `parity_err` for 1 cycle; the word is still delivered.
- Undefined: BW = WIDTH+1 and `parity_err` is constant 0.

## Test plan
- Reset, then idle at clk 100 MHz / 37 MHz, default params, no `tx_valid`: `tok_out` toggles forever, `rx_valid` stays 0, and neither side's `bus_out[WIDTH]` ever goes 1.
- Single word: side A sends 0xBEEF. Side B shows `rx_valid`=1, `rx_data`=0xBEEF exactly once, at most 2 ring periods after acceptance.
- Stream of 1000 incrementing words each way, with `rx_ready` always 1: all words arrive in order, with no loss or duplication.
- Backpressure: hold side B `rx_ready`=0 with `rx_valid`=1. Side B's `tok_out` freezes, side A's `tx_ready` stays 0; releasing `rx_ready` delivers the next word in order.
- `SYNC_STAGES`=3, WIDTH=8, equal clocks: the ring period measures exactly 8 cycles.
- Parity build: flip one `bus_in` data bit in the bench on side B. `parity_err` pulses once, in the capture cycle; no error occurs on clean traffic.
